// File: rtl/sprite_compositor.sv
// N-channel sprite/background mixer: three-stage pipeline from timing counters to an RGB333 pixel,
// with double-buffered sprite configuration and sticky player-collision flags.
module sprite_compositor #(
   parameter int N_SPR = 8,
   parameter int SPR_W = 32,
   parameter int SPR_H = 32,
   parameter int ADDR_W = 10,
   parameter int COLOR_W = 9,
   parameter int H_DISPLAY = 640,
   parameter int V_DISPLAY = 480,
   parameter logic [COLOR_W-1:0] TRANSP = '0,
   localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [9:0]               h_count,
   input  logic [9:0]               v_count,
   input  logic [COLOR_W-1:0]       bg_color,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic [9:0]               cfg_x,
   input  logic [9:0]               cfg_y,
   input  logic                     cfg_en,
   input  logic                     cfg_mirror,
   output logic [N_SPR*ADDR_W-1:0]  spr_addr,
   input  logic [N_SPR*COLOR_W-1:0] spr_data,
   output logic [COLOR_W-1:0]       rgb_out,
   output logic                     de_out,
   output logic [N_SPR-1:0]         collision,
   output logic                     frame_latch
);

   localparam int COL_W = $clog2(SPR_W);

   logic [9:0]         sh_x  [N_SPR];
   logic [9:0]         sh_y  [N_SPR];
   logic [9:0]         act_x [N_SPR];
   logic [9:0]         act_y [N_SPR];
   logic [N_SPR-1:0]   sh_en, sh_mir, act_en, act_mir;

   logic [N_SPR-1:0]   hit_c, hit1, hit2, opaque, coll_next;
   logic [COL_W-1:0]   col_off [N_SPR];
   logic [ADDR_W-1:0]  addr_c  [N_SPR];
   logic               de_c, latch_c, first_c;
   logic               de1, de2, first1, first2;
   logic [COLOR_W-1:0] bg1, bg2, mix_pix;

   assign de_c    = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
   assign latch_c = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
   assign first_c = (h_count == 10'd0) && (v_count == 10'd0);

   // Bounds are compared in 11 bits so a sprite near 1023 does not wrap back to the left edge.
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < N_SPR; i++) begin
         hit_c[i] = act_en[i]
                    && ({1'b0, h_count} >= {1'b0, act_x[i]})
                    && ({1'b0, h_count} <  ({1'b0, act_x[i]} + 11'(SPR_W)))
                    && ({1'b0, v_count} >= {1'b0, act_y[i]})
                    && ({1'b0, v_count} <  ({1'b0, act_y[i]} + 11'(SPR_H)));
         col_off[i] = act_mir[i] ? (COL_W'(SPR_W - 1) - COL_W'(h_count - act_x[i]))
                                 : COL_W'(h_count - act_x[i]);
         addr_c[i] = ADDR_W'(v_count - act_y[i]) * ADDR_W'(SPR_W) + ADDR_W'(col_off[i]);
      end
   end

   // Lower index wins, so the scan runs from the top down and the last opaque hit sticks.
   always_comb begin
      opaque    = '0;
      coll_next = '0;
      mix_pix   = bg2;
      for (int i = 0; i < N_SPR; i++) begin
         opaque[i] = hit2[i] && (spr_data[i*COLOR_W +: COLOR_W] != TRANSP);
      end
      for (int i = N_SPR - 1; i >= 0; i--) begin
         if (opaque[i]) begin
            mix_pix = spr_data[i*COLOR_W +: COLOR_W];
         end
      end
      for (int i = 1; i < N_SPR; i++) begin
         coll_next[i] = (collision[i] && !first2) || (de2 && opaque[0] && opaque[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < N_SPR; i++) begin
            sh_x[i]  <= '0;
            sh_y[i]  <= '0;
            act_x[i] <= '0;
            act_y[i] <= '0;
         end
         sh_en       <= '0;
         sh_mir      <= '0;
         act_en      <= '0;
         act_mir     <= '0;
         spr_addr    <= '0;
         hit1        <= '0;
         hit2        <= '0;
         de1         <= 1'b0;
         de2         <= 1'b0;
         first1      <= 1'b0;
         first2      <= 1'b0;
         bg1         <= '0;
         bg2         <= '0;
         rgb_out     <= '0;
         de_out      <= 1'b0;
         collision   <= '0;
         frame_latch <= 1'b0;
      end else begin
         // The copy reads the shadow before this edge's write, so a coincident write lands a frame later.
         for (int i = 0; i < N_SPR; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
               sh_x[i]   <= cfg_x;
               sh_y[i]   <= cfg_y;
               sh_en[i]  <= cfg_en;
               sh_mir[i] <= cfg_mirror;
            end
            if (latch_c) begin
               act_x[i]   <= sh_x[i];
               act_y[i]   <= sh_y[i];
               act_en[i]  <= sh_en[i];
               act_mir[i] <= sh_mir[i];
            end
            if (hit_c[i]) begin
               spr_addr[i*ADDR_W +: ADDR_W] <= addr_c[i];
            end
         end
         frame_latch <= latch_c;
         hit1        <= hit_c;
         de1         <= de_c;
         bg1         <= bg_color;
         first1      <= first_c;
         hit2        <= hit1;
         de2         <= de1;
         bg2         <= bg1;
         first2      <= first1;
         rgb_out     <= de2 ? mix_pix : '0;
         de_out      <= de2;
         collision   <= coll_next;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: hand-placed pixels with hand-computed colours,
// addresses, collision flags and frame-latch pulses.
module tb_sprite_compositor;

   localparam logic [8:0] BG = 9'h0AA;

   logic        CLK = 1'b0;
   logic        RST;
   logic [9:0]  h_count, v_count;
   logic [8:0]  bg_color;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [9:0]  cfg_x, cfg_y;
   logic        cfg_en, cfg_mirror;
   logic [79:0] spr_addr;
   logic [71:0] spr_data;
   logic [8:0]  rgb_out;
   logic        de_out;
   logic [7:0]  collision;
   logic        frame_latch;

   logic [8:0]  data_v [8];
   int          checks = 0;
   int          errors = 0;

   sprite_compositor dut (
      .CLK(CLK), .RST(RST), .h_count(h_count), .v_count(v_count), .bg_color(bg_color),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
      .cfg_mirror(cfg_mirror), .spr_addr(spr_addr), .spr_data(spr_data), .rgb_out(rgb_out),
      .de_out(de_out), .collision(collision), .frame_latch(frame_latch)
   );

   always #5 CLK = ~CLK;

   // Each sprite RAM returns one fixed colour, so only the hit mask decides what is visible.
   always_comb begin
      spr_data = '0;
      for (int i = 0; i < 8; i++) spr_data[i*9 +: 9] = data_v[i];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic [8:0] bg);
      @(negedge CLK);
      h_count  = h;
      v_count  = v;
      bg_color = bg;
   endtask

   task automatic pixelCheck(input string tag, input logic [9:0] h, input logic [9:0] v,
                             input logic [8:0] exp_rgb, input logic exp_de);
      applyStimulus(h, v, BG);
      applyStimulus(10'd700, 10'd0, 9'h000);
      applyStimulus(10'd700, 10'd0, 9'h000);
      @(negedge CLK);
      checkOutput({tag, " rgb"}, 32'(rgb_out), 32'(exp_rgb));
      checkOutput({tag, " de"}, 32'(de_out), 32'(exp_de));
   endtask

   task automatic addrCheck(input string tag, input logic [9:0] h, input logic [9:0] v,
                            input int ch, input logic [9:0] exp_addr);
      applyStimulus(h, v, BG);
      applyStimulus(10'd700, 10'd0, 9'h000);
      checkOutput(tag, 32'(spr_addr[ch*10 +: 10]), 32'(exp_addr));
   endtask

   task automatic writeCfg(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                           input logic en, input logic mir);
      @(negedge CLK);
      cfg_we = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_en = en; cfg_mirror = mir;
      h_count = 10'd700; v_count = 10'd0;
      @(negedge CLK);
      cfg_we = 1'b0;
   endtask

   task automatic latchFrame(input string tag);
      applyStimulus(10'd0, 10'd480, 9'h000);
      applyStimulus(10'd700, 10'd0, 9'h000);
      checkOutput({tag, " pulse"}, 32'(frame_latch), 32'd1);
      @(negedge CLK);
      checkOutput({tag, " pulse end"}, 32'(frame_latch), 32'd0);
   endtask

   initial begin
      RST = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
      cfg_mirror = 1'b0; h_count = 10'd700; v_count = 10'd0; bg_color = '0;
      for (int i = 0; i < 8; i++) data_v[i] = 9'h000;
      repeat (3) @(negedge CLK);
      checkOutput("reset rgb", 32'(rgb_out), 32'd0);
      checkOutput("reset de", 32'(de_out), 32'd0);
      checkOutput("reset collision", 32'(collision), 32'd0);
      checkOutput("reset frame_latch", 32'(frame_latch), 32'd0);
      checkOutput("reset spr_addr", 32'(|spr_addr), 32'd0);
      RST = 1'b0;

      $display("[TB] single sprite placement and latency");
      data_v[0] = 9'h1C7;
      writeCfg(3'd0, 10'd100, 10'd50, 1'b1, 1'b0);
      pixelCheck("shadow only", 10'd100, 10'd50, BG, 1'b1);
      latchFrame("latch1");
      addrCheck("ch0 addr origin", 10'd100, 10'd50, 0, 10'd0);
      addrCheck("ch0 addr interior", 10'd105, 10'd52, 0, 10'd69);
      pixelCheck("ch0 origin", 10'd100, 10'd50, 9'h1C7, 1'b1);
      pixelCheck("ch0 right edge", 10'd132, 10'd50, BG, 1'b1);
      pixelCheck("ch0 left of", 10'd99, 10'd50, BG, 1'b1);
      pixelCheck("ch0 last row", 10'd100, 10'd81, 9'h1C7, 1'b1);
      pixelCheck("ch0 below", 10'd100, 10'd82, BG, 1'b1);

      $display("[TB] priority, transparency and collision");
      data_v[1] = 9'h038;
      writeCfg(3'd0, 10'd200, 10'd100, 1'b1, 1'b0);
      writeCfg(3'd1, 10'd200, 10'd100, 1'b1, 1'b0);
      latchFrame("latch2");
      pixelCheck("both opaque", 10'd210, 10'd110, 9'h1C7, 1'b1);
      checkOutput("collision ch1", 32'(collision), 32'h02);
      pixelCheck("frame start", 10'd0, 10'd0, BG, 1'b1);
      checkOutput("collision cleared", 32'(collision), 32'h00);
      data_v[0] = 9'h000;
      pixelCheck("ch0 transparent", 10'd210, 10'd110, 9'h038, 1'b1);
      checkOutput("no collision transp", 32'(collision), 32'h00);
      data_v[1] = 9'h000;
      pixelCheck("both transparent", 10'd210, 10'd110, BG, 1'b1);
      checkOutput("no collision both", 32'(collision), 32'h00);

      $display("[TB] mirroring");
      writeCfg(3'd2, 10'd0, 10'd0, 1'b1, 1'b1);
      latchFrame("latch3");
      addrCheck("mirror h0", 10'd0, 10'd1, 2, 10'd63);
      addrCheck("mirror h31", 10'd31, 10'd1, 2, 10'd32);

      $display("[TB] tear-free position update");
      data_v[3] = 9'h1FF;
      writeCfg(3'd3, 10'd400, 10'd200, 1'b1, 1'b0);
      latchFrame("latch4");
      pixelCheck("ch3 old x", 10'd400, 10'd200, 9'h1FF, 1'b1);
      writeCfg(3'd3, 10'd300, 10'd200, 1'b1, 1'b0);
      pixelCheck("ch3 old x held", 10'd400, 10'd210, 9'h1FF, 1'b1);
      pixelCheck("ch3 new x not yet", 10'd300, 10'd210, BG, 1'b1);
      latchFrame("latch5");
      pixelCheck("ch3 new x", 10'd300, 10'd210, 9'h1FF, 1'b1);
      pixelCheck("ch3 old x gone", 10'd400, 10'd210, BG, 1'b1);
      @(negedge CLK);
      cfg_we = 1'b1; cfg_idx = 3'd3; cfg_x = 10'd500; cfg_y = 10'd200; cfg_en = 1'b1;
      cfg_mirror = 1'b0; h_count = 10'd0; v_count = 10'd480;
      @(negedge CLK);
      cfg_we = 1'b0; h_count = 10'd700; v_count = 10'd0;
      checkOutput("coincident pulse", 32'(frame_latch), 32'd1);
      pixelCheck("coincident keeps old", 10'd300, 10'd210, 9'h1FF, 1'b1);
      latchFrame("latch6");
      pixelCheck("coincident next frame", 10'd500, 10'd210, 9'h1FF, 1'b1);
      writeCfg(3'd3, 10'd1010, 10'd200, 1'b1, 1'b0);
      latchFrame("latch7");
      addrCheck("no wrap at 1023", 10'd1015, 10'd210, 3, 10'd325);

      $display("[TB] sticky collision and blanking");
      data_v[0] = 9'h1C7;
      data_v[4] = 9'h03F;
      writeCfg(3'd0, 10'd0, 10'd0, 1'b1, 1'b0);
      writeCfg(3'd4, 10'd0, 10'd0, 1'b1, 1'b0);
      latchFrame("latch8");
      pixelCheck("overlap", 10'd5, 10'd5, 9'h1C7, 1'b1);
      checkOutput("collision ch4 set", 32'(collision), 32'h10);
      pixelCheck("vblank", 10'd5, 10'd490, 9'h000, 1'b0);
      checkOutput("collision held vblank", 32'(collision), 32'h10);
      pixelCheck("hblank", 10'd700, 10'd100, 9'h000, 1'b0);
      pixelCheck("set beats clear", 10'd0, 10'd0, 9'h1C7, 1'b1);
      checkOutput("set beats clear coll", 32'(collision), 32'h10);
      data_v[4] = 9'h000;
      pixelCheck("clear at origin", 10'd0, 10'd0, 9'h1C7, 1'b1);
      checkOutput("collision cleared 2", 32'(collision), 32'h00);

      $display("[TB] reset mid-line");
      data_v[4] = 9'h03F;
      pixelCheck("pre-reset", 10'd5, 10'd5, 9'h1C7, 1'b1);
      checkOutput("pre-reset collision", 32'(collision), 32'h10);
      applyStimulus(10'd5, 10'd5, BG);
      applyStimulus(10'd5, 10'd5, BG);
      applyStimulus(10'd5, 10'd5, BG);
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("mid reset rgb", 32'(rgb_out), 32'd0);
      checkOutput("mid reset de", 32'(de_out), 32'd0);
      checkOutput("mid reset addr", 32'(|spr_addr), 32'd0);
      checkOutput("mid reset collision", 32'(collision), 32'h00);
      checkOutput("mid reset frame_latch", 32'(frame_latch), 32'd0);
      h_count = 10'd700; v_count = 10'd0;
      @(negedge CLK);
      RST = 1'b0;
      pixelCheck("post reset disabled", 10'd5, 10'd5, BG, 1'b1);
      checkOutput("post reset collision", 32'(collision), 32'h00);
      latchFrame("latch9");
      pixelCheck("shadow cleared", 10'd5, 10'd5, BG, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
